// File: rtl/load_align_unit.sv
// Load-side aligner: issues one word-aligned memory read per request, then
// extracts and sign/zero-extends the addressed byte or halfword for writeback.
module load_align_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [2:0]       req_funct3,
  input  logic [TAG_W-1:0] req_tag,
  output logic             dmem_read,
  output logic [31:0]      dmem_address,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_misaligned
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  state_t      state;
  logic [1:0]  off;
  logic [2:0]  funct3;
  logic        misaligned;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] extracted;

  assign req_ready = (state == IDLE);
  assign dmem_read = (state == MEM_WAIT);
  assign rsp_valid = (state == RESP);

  // Illegal funct3 codes fall into the default arm and behave as lw.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      F_LB, F_LBU: misaligned = 1'b0;
      F_LH, F_LHU: misaligned = req_addr[0];
      default:     misaligned = |req_addr[1:0];
    endcase
  end

  always_comb begin
    byte_val  = dmem_rdata[{off, 3'b000} +: 8];
    half_val  = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    extracted = dmem_rdata;
    case (funct3)
      F_LB:    extracted = {{24{byte_val[7]}}, byte_val};
      F_LBU:   extracted = {24'd0, byte_val};
      F_LH:    extracted = {{16{half_val[15]}}, half_val};
      F_LHU:   extracted = {16'd0, half_val};
      default: extracted = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      off            <= '0;
      funct3         <= '0;
      dmem_address   <= '0;
      rsp_data       <= '0;
      rsp_tag        <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off          <= req_addr[1:0];
            funct3       <= req_funct3;
            rsp_tag      <= req_tag;
            dmem_address <= {req_addr[31:2], 2'b00};
            if (misaligned) begin
              rsp_data       <= '0;
              rsp_misaligned <= 1'b1;
              state          <= RESP;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_resp) begin
            rsp_data       <= extracted;
            rsp_misaligned <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
